bft_demux: RTL
==============

Name: bft_demux

Overview:
- Registered 1:2 packet demultiplexer for the BFT switch fabric; the split-side counterpart of the registered 2:1 select stage.
- Steers a valid/ready flit stream to one of two downstream ports using one routing bit of the header flit.
- Holds the route for the rest of the packet, so flits are never interleaved.
- Each output port has a small FIFO that decouples upstream from downstream back-pressure.

Parameters:
- DATA_W, 32, flit payload width in bits
- DEPTH, 2, entries per output FIFO; power of 2, >= 2
- SEL_BIT, 0, index into in_data of the header flit used as the route bit (0 -> port 0, 1 -> port 1)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_data  input  DATA_W  incoming flit
- in_last  input  1  flit is the last of its packet
- in_valid  input  1  upstream flit valid
- in_ready  output  1  flit accepted when in_valid && in_ready
- out0_data  output  DATA_W  port 0 head flit
- out0_last  output  1  port 0 head flit is last
- out0_valid  output  1  port 0 FIFO non-empty
- out0_ready  input  1  port 0 downstream accepts
- out1_data / out1_last / out1_valid / out1_ready: same as port 0, for port 1
- busy  output  1  route locked (packet in progress)
- route  output  1  locked destination; valid only while busy=1

Behaviour:
- Reset: clk and rst only; reset is synchronous, active-high.
  - FSM returns to IDLE; both FIFO counts and pointers go to 0.
  - FIFO storage is cleared, so out*_data=0, out*_last=0, out*_valid=0, busy=0, route=0.
  - Reset mid-packet discards the partial packet and all buffered flits. There is no flush handshake.
- FSM states: IDLE, LOCK0, LOCK1.
  - IDLE: header flit; destination d = in_data[SEL_BIT].
    - in_ready = !full[d].
    - On accept with in_last=1, stay in IDLE (single-flit packet).
    - On accept with in_last=0, go to LOCKd.
  - LOCKd: every flit goes to port d; in_ready = !full[d]; the other port's state does not affect in_ready.
    - On accept with in_last=1, return to IDLE.
    - in_valid=0 holds the state.
  - busy = (state != IDLE); route = d while locked.
- Data path: flits are forwarded unmodified, route bit included. Per-port order is preserved.
- FIFO, per port:
  - count 0..DEPTH; full = (count==DEPTH); out_valid = (count!=0).
  - out_data and out_last come from the registered head entry, with no combinational path from in_data.
  - Write on accept; read on out_valid && out_ready.
  - Simultaneous read and write: count unchanged, pointers both advance.
  - Full port: in_ready=0 even if a read happens in the same cycle (no bypass). in_ready never depends on out*_ready.
  - Read and write pointers wrap modulo DEPTH.
- Latency: a flit accepted in cycle N is visible on outd_* in cycle N+1 if its FIFO was empty.
  - Throughput is 1 flit/cycle when the downstream is always ready.
- Output handshake: once out*_valid=1, it stays high with data and last stable until the flit is accepted.
- Blocking: an IDLE header to a full port blocks the input. The flit is not rerouted and there is no head-of-line bypass.
- Illegal/ignored:
  - in_data changes while in_valid=1 && in_ready=0 are not checked.
  - The route bit of non-header flits is ignored.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> all out*_valid=0, out*_data=0, busy=0, in_ready=1.
- Single-flit routing:
  - Send 0x00000004 (bit0=0), last=1 -> out0_valid=1 next cycle with 0x00000004, last=1; busy stays 0.
  - Then send 0x00000005, last=1 -> emerges on out1.
- Multi-flit lock:
  - Header 0x00000001, last=0, then 0xAAAA0000 and 0x55550000 (last=1) -> all three appear on out1 in order.
  - busy=1 and route=1 from the cycle after the header until the cycle after the last flit.
  - out0_valid stays 0 throughout.
- Back-pressure/full:
  - Hold out0_ready=0 and send 3 single flits to port 0 -> first two accepted; in_ready=0 on the third.
  - Raise out0_ready -> third flit accepted the cycle after the first pop.
  - No flit is lost or duplicated.
- Streaming with simultaneous read/write:
  - Both out*_ready=1, 16 back-to-back flits alternating ports -> in_ready=1 every cycle.
  - Outputs match inputs shifted by 1 cycle; counts never exceed 1.
- Reset mid-packet:
  - Header to port 0, last=0, plus one body flit buffered, out0_ready=0, then assert rst -> next cycle state IDLE, busy=0, out0_valid=0.
  - A following single-flit packet to port 1 routes correctly.

Source files
------------

// File: rtl/bft_demux.sv
// bft_demux: registered 1:2 packet demultiplexer for the BFT switch fabric.
//
// The header flit of each packet picks a destination port from bit SEL_BIT of
// its payload. The route is then held until the last flit of the packet is
// accepted, so packets are never interleaved on an output. Each output port has
// its own DEPTH-entry FIFO, so back-pressure on one port is isolated from the
// other port except while a packet is being steered towards the full port.
//
// Ports:
//   clk, rst                    clock; synchronous active-high reset
//   in_data/in_last/in_valid    upstream flit stream
//   in_ready                    upstream flit accepted when in_valid && in_ready
//   out0_* / out1_*             per-port downstream valid/ready streams
//   busy                        a packet is in progress and its route is locked
//   route                       locked destination port, meaningful while busy=1
//
// State | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a header flit; its route bit picks the port
// LOCK0 | mid-packet, every flit goes to port 0 until in_last
// LOCK1 | mid-packet, every flit goes to port 1 until in_last

module bft_demux #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 2,
    parameter int SEL_BIT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out0_data,
    output logic              out0_last,
    output logic              out0_valid,
    input  logic              out0_ready,
    output logic [DATA_W-1:0] out1_data,
    output logic              out1_last,
    output logic              out1_valid,
    input  logic              out1_ready,
    output logic              busy,
    output logic              route
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic             dest;
    logic             accept;
    logic [1:0]       full;
    logic [1:0]       not_empty;
    logic [1:0]       wr_en;
    logic [1:0]       rd_en;

    logic [CNT_W-1:0]  count_q     [2];
    logic [PTR_W-1:0]  wr_ptr_q    [2];
    logic [PTR_W-1:0]  rd_ptr_q    [2];
    logic [DATA_W-1:0] mem_data_q  [2][DEPTH];
    logic              mem_last_q  [2][DEPTH];

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            full[p]      = (count_q[p] == CNT_W'(DEPTH));
            not_empty[p] = (count_q[p] != '0);
        end
    end

    // Destination and in_ready depend only on the FSM state, the header route
    // bit and the destination FIFO fill level, never on the downstream ready
    // inputs, so a full port blocks even when it is being drained this cycle.
    always_comb begin
        state_d = state_q;
        dest    = 1'b0;
        case (state_q)
            IDLE:    dest = in_data[SEL_BIT];
            LOCK0:   dest = 1'b0;
            LOCK1:   dest = 1'b1;
            default: dest = 1'b0;
        endcase

        in_ready = !full[dest];
        accept   = in_valid && in_ready;

        if (accept) begin
            if (in_last) begin
                state_d = IDLE;
            end else if (state_q == IDLE) begin
                state_d = dest ? LOCK1 : LOCK0;
            end
        end

        wr_en = 2'b00;
        if (accept) begin
            wr_en[dest] = 1'b1;
        end
        rd_en = not_empty & {out1_ready, out0_ready};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Reset also clears the storage so the head outputs read zero afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < 2; p++) begin
                count_q[p]  <= '0;
                wr_ptr_q[p] <= '0;
                rd_ptr_q[p] <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    mem_data_q[p][i] <= '0;
                    mem_last_q[p][i] <= 1'b0;
                end
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (wr_en[p]) begin
                    mem_data_q[p][wr_ptr_q[p]] <= in_data;
                    mem_last_q[p][wr_ptr_q[p]] <= in_last;
                    wr_ptr_q[p]                <= wr_ptr_q[p] + PTR_W'(1);
                end
                if (rd_en[p]) begin
                    rd_ptr_q[p] <= rd_ptr_q[p] + PTR_W'(1);
                end
                case ({wr_en[p], rd_en[p]})
                    2'b10:   count_q[p] <= count_q[p] + CNT_W'(1);
                    2'b01:   count_q[p] <= count_q[p] - CNT_W'(1);
                    default: count_q[p] <= count_q[p];
                endcase
            end
        end
    end

    assign out0_data  = mem_data_q[0][rd_ptr_q[0]];
    assign out0_last  = mem_last_q[0][rd_ptr_q[0]];
    assign out0_valid = not_empty[0];
    assign out1_data  = mem_data_q[1][rd_ptr_q[1]];
    assign out1_last  = mem_last_q[1][rd_ptr_q[1]];
    assign out1_valid = not_empty[1];

    assign busy  = (state_q != IDLE);
    assign route = (state_q == LOCK1);

endmodule
